// File: rtl/bch_encode_scheduler_pkg.sv
// Shared types and elaboration helpers for the BCH encode scheduler.
package bch_encode_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    // Ceiling log2, never below 1 so that single-bit fields stay legal.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem / 32'sd2;
        end
        return (result < 32'sd1) ? 32'sd1 : result;
    endfunction

endpackage

// File: rtl/bch_rr_arbiter.sv
// Combinational round-robin search: first set request strictly after last_grant, with wrap.
module bch_rr_arbiter
    import bch_encode_scheduler_pkg::*;
#(
    parameter int  C_N_REQ = 4,
    localparam int ID_W    = clog2(C_N_REQ)
) (
    input  logic [C_N_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        int idx;
        idx         = 32'sd0;
        grant_valid = 1'b0;
        grant_id    = {ID_W{1'b0}};
        for (int off = C_N_REQ; off >= 32'sd1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= C_N_REQ) begin
                idx = idx - C_N_REQ;
            end else begin
                idx = idx;
            end
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end else begin
                grant_valid = grant_valid;
                grant_id    = grant_id;
            end
        end
    end

endmodule

// File: rtl/bch_encode_scheduler.sv
// Shares one BCH wrapper encoder among several requesters: arbitrates, sequences
// the wrapper enable/start, relocates its memory writes and returns ack/err.
module bch_encode_scheduler
    import bch_encode_scheduler_pkg::*;
#(
    parameter int  C_N_REQ         = 4,
    parameter int  C_DATA_W        = 4,
    parameter int  C_MEM_ADDR_SIZE = 10,
    parameter int  C_MEM_DATA_SIZE = 8,
    parameter int  C_BASE_ADDR     = 0,
    parameter int  C_SLOT_WORDS    = 4,
    parameter int  C_TIMEOUT       = 1023,
    localparam int ID_W            = clog2(C_N_REQ)
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_en,
    input  logic [C_N_REQ-1:0]            I_req,
    input  logic [C_N_REQ*C_DATA_W-1:0]   I_data,
    output logic [C_N_REQ-1:0]            O_ack,
    output logic                          O_err,
    output logic                          O_busy,
    output logic [ID_W-1:0]               O_grant_id,
    output logic                          O_enc_en,
    output logic                          O_enc_start,
    output logic [C_DATA_W-1:0]           O_enc_data,
    input  logic                          I_enc_ready,
    input  logic                          I_enc_wen,
    input  logic [C_MEM_ADDR_SIZE-1:0]    I_enc_waddr,
    input  logic [C_MEM_DATA_SIZE-1:0]    I_enc_wdata,
    output logic [C_MEM_ADDR_SIZE-1:0]    O_mem_waddr,
    output logic [C_MEM_DATA_SIZE-1:0]    O_mem_wdata,
    output logic                          O_wen
);

    localparam int                   TMO_W    = clog2(C_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(C_TIMEOUT - 1);
    localparam logic [ID_W-1:0]      LAST_RST = ID_W'(C_N_REQ - 1);
    localparam logic [C_N_REQ-1:0]   ACK_ONE  = C_N_REQ'(32'd1);

    sched_state_e                  state_r;
    sched_state_e                  state_s;
    logic                          err_s;
    logic                          arm_cnt_r;
    logic [TMO_W-1:0]              tmo_cnt_r;
    logic [ID_W-1:0]               last_grant_r;
    logic [ID_W-1:0]               grant_id_r;
    logic [C_DATA_W-1:0]           enc_data_r;
    logic [C_N_REQ-1:0]            ack_r;
    logic                          err_r;
    logic                          busy_r;
    logic                          enc_en_r;
    logic                          enc_start_r;
    logic                          wen_r;
    logic [C_MEM_ADDR_SIZE-1:0]    waddr_r;
    logic [C_MEM_DATA_SIZE-1:0]    wdata_r;
    logic                          grant_valid_s;
    logic [ID_W-1:0]               arb_id_s;
    logic [C_DATA_W-1:0]           sel_data_s;
    logic [C_MEM_ADDR_SIZE-1:0]    reloc_addr_s;

    bch_rr_arbiter #(
        .C_N_REQ     (C_N_REQ)
    ) u_arbiter (
        .req         (I_req),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (arb_id_s)
    );

    // Select the data word of the requester the arbiter is offering.
    always_comb begin
        sel_data_s = {C_DATA_W{1'b0}};
        for (int i = 0; i < C_N_REQ; i++) begin
            if (ID_W'(i) == arb_id_s) begin
                sel_data_s = I_data[i*C_DATA_W +: C_DATA_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Wrapper addresses start at 0; shift them into the granted requester's slot.
    assign reloc_addr_s = C_MEM_ADDR_SIZE'(C_BASE_ADDR)
                        + C_MEM_ADDR_SIZE'(grant_id_r) * C_MEM_ADDR_SIZE'(C_SLOT_WORDS)
                        + I_enc_waddr;

    // Next-state decode; ready takes precedence over the timeout in the same cycle.
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) state_s = ST_ARM;
                else               state_s = ST_IDLE;
            end
            ST_ARM: begin
                if (arm_cnt_r) state_s = ST_RUN;
                else           state_s = ST_ARM;
            end
            ST_RUN: begin
                if (I_enc_ready) begin
                    state_s = ST_DONE;
                    err_s   = 1'b0;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_RUN;
                    err_s   = 1'b0;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counters, grant/data latch and the registered control outputs.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r      <= ST_IDLE;
            arm_cnt_r    <= 1'b0;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            last_grant_r <= LAST_RST;
            grant_id_r   <= {ID_W{1'b0}};
            enc_data_r   <= {C_DATA_W{1'b0}};
            ack_r        <= {C_N_REQ{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            enc_en_r     <= 1'b0;
            enc_start_r  <= 1'b0;
        end else if (!I_en) begin
            // Abort without ack; last_grant survives so fairness is not reset.
            state_r      <= ST_IDLE;
            arm_cnt_r    <= 1'b0;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            last_grant_r <= last_grant_r;
            grant_id_r   <= {ID_W{1'b0}};
            enc_data_r   <= {C_DATA_W{1'b0}};
            ack_r        <= {C_N_REQ{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            enc_en_r     <= 1'b0;
            enc_start_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            arm_cnt_r <= (state_r == ST_ARM) && !arm_cnt_r;
            if ((state_r == ST_RUN) && (state_s == ST_RUN)) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            if ((state_r == ST_IDLE) && grant_valid_s) begin
                grant_id_r <= arb_id_s;
                enc_data_r <= sel_data_s;
            end else begin
                grant_id_r <= grant_id_r;
                enc_data_r <= enc_data_r;
            end
            if (state_r == ST_DONE) begin
                last_grant_r <= grant_id_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
            enc_en_r    <= (state_s == ST_ARM) || (state_s == ST_RUN);
            enc_start_r <= (state_s == ST_RUN);
            busy_r      <= (state_s != ST_IDLE);
            ack_r       <= (state_s == ST_DONE) ? (ACK_ONE << grant_id_r) : {C_N_REQ{1'b0}};
            err_r       <= (state_s == ST_DONE) && err_s;
        end
    end

    // Helper-data write port: forwards wrapper writes only while the job is running.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wen_r   <= 1'b0;
            waddr_r <= {C_MEM_ADDR_SIZE{1'b0}};
            wdata_r <= {C_MEM_DATA_SIZE{1'b0}};
        end else if (!I_en) begin
            wen_r   <= 1'b0;
            waddr_r <= {C_MEM_ADDR_SIZE{1'b0}};
            wdata_r <= {C_MEM_DATA_SIZE{1'b0}};
        end else begin
            wen_r   <= I_enc_wen && (state_r == ST_RUN);
            waddr_r <= reloc_addr_s;
            wdata_r <= I_enc_wdata;
        end
    end

    assign O_ack       = ack_r;
    assign O_err       = err_r;
    assign O_busy      = busy_r;
    assign O_grant_id  = grant_id_r;
    assign O_enc_en    = enc_en_r;
    assign O_enc_start = enc_start_r;
    assign O_enc_data  = enc_data_r;
    assign O_wen       = wen_r;
    assign O_mem_waddr = waddr_r;
    assign O_mem_wdata = wdata_r;

endmodule
